// File: rtl/rv32_pkg.sv
// Shared fetch-side definitions for the RV32IMC core: reset PC, fetch FSM
// states and the compressed-instruction test.
package rv32_pkg;

  localparam logic [31:0] RV32_RESET_PC = 32'h1000_0000;

  typedef enum logic [1:0] {
    ST_DECIDE,
    ST_FETCH,
    ST_ISSUE,
    ST_FAULT
  } fetch_state_e;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rv32_fetch_ctrl_if.sv
// Instruction-memory req/ack bus and decode valid/ready handshake seen by the
// fetch sequencer (master) and by memory plus decode (slave).
interface rv32_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_ack, imem_rdata, imem_err, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_ack, imem_rdata, imem_err, instr_ready
  );
endinterface

// File: rtl/rv32_fetch_align.sv
// Combinational instruction alignment: picks a halfword or word out of the
// buffered fetch word, or glues a straddling instruction from spill + new word.
module rv32_fetch_align
  import rv32_pkg::*;
(
  input  logic        pc_hi,
  input  logic [31:0] buf_word,
  input  logic [15:0] spill_hi,
  input  logic [15:0] rdata,
  input  logic        span,
  output logic [31:0] instr_data,
  output logic        compressed,
  output logic        need_span
);

  logic [15:0] sel_hw;
  logic        sel_c;

  always_comb begin
    sel_hw     = pc_hi ? buf_word[31:16] : buf_word[15:0];
    sel_c      = is_compressed(sel_hw);
    instr_data = 32'h0;
    compressed = 1'b0;
    need_span  = 1'b0;
    if (span) begin
      instr_data = {rdata, spill_hi};
    end else if (sel_c) begin
      instr_data = {16'h0, sel_hw};
      compressed = 1'b1;
    end else if (!pc_hi) begin
      instr_data = buf_word;
    end else begin
      // 32-bit instruction in the upper halfword continues in the next word
      need_span = 1'b1;
    end
  end

endmodule

// File: rtl/rv32_fetch_ctrl.sv
// Instruction-fetch sequencer: one-word buffer, straddle assembly, decode
// handshake, PC register control and redirect/fault handling.
module rv32_fetch_ctrl
  import rv32_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_current,
  output logic               pc_stall,
  output logic               pc_is_compressed,
  output logic               pc_overwrite_enable,
  output logic [31:0]        pc_overwrite_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               fetch_fault,
  rv32_fetch_ctrl_if.master  bus
);

  fetch_state_e state;
  logic         drain;
  logic         buf_valid;
  logic [29:0]  buf_tag;
  logic [31:0]  buf_word;
  logic [15:0]  spill_hi;
  logic         span;
  logic         instr_comp;
  logic         imem_req_r;
  logic [31:0]  imem_addr_r;
  logic         instr_valid_r;
  logic [31:0]  instr_data_r;
  logic [31:0]  instr_pc_r;
  logic         fault_r;

  logic [31:0]  al_instr;
  logic         al_comp;
  logic         al_need_span;
  logic         hit;
  logic         accept;
  logic         ack_ok;
  logic         unused_bits;

  rv32_fetch_align u_align (
    .pc_hi      (pc_current[1]),
    .buf_word   (buf_word),
    .spill_hi   (spill_hi),
    .rdata      (bus.imem_rdata[15:0]),
    .span       (span),
    .instr_data (al_instr),
    .compressed (al_comp),
    .need_span  (al_need_span)
  );

  assign hit    = buf_valid && (buf_tag == pc_current[31:2]);
  assign accept = (state == ST_ISSUE) && bus.instr_ready && !redirect_valid;
  assign ack_ok = (state == ST_FETCH) && bus.imem_ack && !bus.imem_err &&
                  !drain && !redirect_valid;

  // Redirect beats accept: the PC loads the target instead of stepping.
  assign pc_stall            = !(accept || redirect_valid);
  assign pc_is_compressed    = instr_comp;
  assign pc_overwrite_enable = redirect_valid;
  assign pc_overwrite_data   = {redirect_pc[31:1], 1'b0};
  assign fetch_fault         = fault_r;

  assign bus.imem_req    = imem_req_r;
  assign bus.imem_addr   = imem_addr_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.instr_data  = instr_data_r;
  assign bus.instr_pc    = instr_pc_r;

  assign unused_bits = ^{pc_current[0], redirect_pc[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_DECIDE;
      drain         <= 1'b0;
      buf_valid     <= 1'b0;
      span          <= 1'b0;
      instr_comp    <= 1'b0;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= 32'h0;
      instr_valid_r <= 1'b0;
      instr_data_r  <= 32'h0;
      instr_pc_r    <= 32'h0;
      fault_r       <= 1'b0;
    end else if (redirect_valid) begin
      buf_valid     <= 1'b0;
      span          <= 1'b0;
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
      // A request still in flight must complete on the bus; swallow its ack.
      if (imem_req_r && !bus.imem_ack) begin
        state <= ST_FETCH;
        drain <= 1'b1;
      end else begin
        state      <= ST_DECIDE;
        drain      <= 1'b0;
        imem_req_r <= 1'b0;
      end
    end else begin
      case (state)
        ST_DECIDE: begin
          if (hit && !al_need_span) begin
            instr_valid_r <= 1'b1;
            instr_data_r  <= al_instr;
            instr_pc_r    <= pc_current;
            instr_comp    <= al_comp;
            state         <= ST_ISSUE;
          end else begin
            imem_req_r <= 1'b1;
            state      <= ST_FETCH;
            if (hit) begin
              span        <= 1'b1;
              imem_addr_r <= {pc_current[31:2] + 30'd1, 2'b00};
            end else begin
              span        <= 1'b0;
              imem_addr_r <= {pc_current[31:2], 2'b00};
            end
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            imem_req_r <= 1'b0;
            if (drain) begin
              drain <= 1'b0;
              state <= ST_DECIDE;
            end else if (bus.imem_err) begin
              buf_valid <= 1'b0;
              fault_r   <= 1'b1;
              state     <= ST_FAULT;
            end else begin
              buf_valid <= 1'b1;
              if (span) begin
                span          <= 1'b0;
                instr_valid_r <= 1'b1;
                instr_data_r  <= al_instr;
                instr_pc_r    <= pc_current;
                instr_comp    <= 1'b0;
                state         <= ST_ISSUE;
              end else begin
                state <= ST_DECIDE;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (bus.instr_ready) begin
            instr_valid_r <= 1'b0;
            state         <= ST_DECIDE;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: state <= ST_DECIDE;
      endcase
    end
  end

  // Buffer contents are qualified by buf_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if ((state == ST_DECIDE) && !redirect_valid && hit && al_need_span)
      spill_hi <= buf_word[31:16];
    if (ack_ok) begin
      buf_word <= bus.imem_rdata;
      buf_tag  <= imem_addr_r[31:2];
    end
  end

endmodule

// File: tb/tb_rv32_fetch_ctrl.sv
// Self-checking bench for rv32_fetch_ctrl with a PC register, a latency-random
// memory and an instruction-stream reference derived from memory contents.
module tb_rv32_fetch_ctrl;
  import rv32_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_current;
  logic        pc_stall, pc_is_compressed, pc_overwrite_enable;
  logic [31:0] pc_overwrite_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  rv32_fetch_ctrl_if bus();

  rv32_fetch_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .pc_current          (pc_current),
    .pc_stall            (pc_stall),
    .pc_is_compressed    (pc_is_compressed),
    .pc_overwrite_enable (pc_overwrite_enable),
    .pc_overwrite_data   (pc_overwrite_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .fetch_fault         (fetch_fault),
    .bus                 (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register with synchronous reset
  always @(posedge clk) begin
    if (reset) pc_current <= RV32_RESET_PC;
    else if (pc_overwrite_enable) pc_current <= pc_overwrite_data;
    else if (!pc_stall) pc_current <= pc_current + (pc_is_compressed ? 32'd2 : 32'd4);
  end

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc, lat_max, wait_cnt, ack_cyc, n_acc, ready_mode;
  bit          req_seen, redir_now, err_en, fault_seen;
  logic [31:0] req_addr, exp_pc, redir_target, err_addr, salt;
  logic [31:0] req_log[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_data[$];
  int          acc_cyc_q[$];
  logic [31:0] overlay [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (overlay.exists(w)) return overlay[w];
    return (w * 32'h9E3779B1) ^ (w >> 11) ^ salt;
  endfunction

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction at address pc as the program image defines it.
  task automatic ref_instr(input logic [31:0] pc, output logic [31:0] data, output logic comp);
    logic [15:0] h0;
    h0 = half(pc);
    if (h0[1:0] != 2'b11) begin
      data = {16'h0, h0};
      comp = 1'b1;
    end else begin
      data = {half(pc + 32'd2), h0};
      comp = 1'b0;
    end
  endtask

  task automatic cycle();
    logic [31:0] rd;
    logic        rc;
    @(negedge clk);
    cyc++;
    bus.imem_ack   = 1'b0;
    bus.imem_err   = 1'b0;
    bus.imem_rdata = 32'h0;
    if (bus.imem_req === 1'b1) begin
      vectors++;
      if (!req_seen) begin
        req_seen = 1'b1;
        req_addr = bus.imem_addr;
        req_log.push_back(bus.imem_addr);
        if (bus.imem_addr[1:0] !== 2'b00) begin
          miscompares++;
          $display("FAIL addr_align: imem_addr=%h, low bits must be 00", bus.imem_addr);
        end
      end else if (bus.imem_addr !== req_addr) begin
        miscompares++;
        $display("FAIL addr_stable: imem_addr=%h, held value %h", bus.imem_addr, req_addr);
      end
      if (wait_cnt == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        bus.imem_err   = err_en && (bus.imem_addr == err_addr);
        ack_cyc        = cyc;
        req_seen       = 1'b0;
        wait_cnt       = int'($urandom_range(0, lat_max));
      end else begin
        wait_cnt--;
      end
    end
    case (ready_mode)
      0:       bus.instr_ready = 1'b0;
      1:       bus.instr_ready = 1'b1;
      default: bus.instr_ready = 1'($urandom_range(0, 1));
    endcase
    redirect_valid = redir_now;
    redirect_pc    = redir_target;
    redir_now      = 1'b0;
    #1;
    if (redirect_valid) begin
      vectors++;
      if (pc_overwrite_enable !== 1'b1 || pc_stall !== 1'b0 ||
          pc_overwrite_data !== {redirect_pc[31:1], 1'b0}) begin
        miscompares++;
        $display("FAIL redirect_out: en=%b stall=%b data=%h, need en=1 stall=0 data=%h",
                 pc_overwrite_enable, pc_stall, pc_overwrite_data, {redirect_pc[31:1], 1'b0});
      end
      exp_pc = {redirect_pc[31:1], 1'b0};
    end else if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
      ref_instr(exp_pc, rd, rc);
      vectors++;
      if (bus.instr_pc !== exp_pc || pc_current !== exp_pc) begin
        miscompares++;
        $display("FAIL instr_pc: instr_pc=%h pc_current=%h, need %h", bus.instr_pc, pc_current, exp_pc);
      end
      vectors++;
      if (bus.instr_data !== rd) begin
        miscompares++;
        $display("FAIL instr_data: got %h at pc %h, need %h", bus.instr_data, exp_pc, rd);
      end
      vectors++;
      if (pc_stall !== 1'b0 || pc_is_compressed !== rc || pc_overwrite_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL accept_ctl: stall=%b comp=%b ovr=%b, need stall=0 comp=%b ovr=0",
                 pc_stall, pc_is_compressed, pc_overwrite_enable, rc);
      end
      acc_pc.push_back(bus.instr_pc);
      acc_data.push_back(bus.instr_data);
      acc_cyc_q.push_back(cyc);
      exp_pc = exp_pc + (rc ? 32'd2 : 32'd4);
      n_acc++;
    end else begin
      vectors++;
      if (pc_stall !== 1'b1 || pc_overwrite_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_stall: stall=%b ovr=%b, need stall=1 ovr=0", pc_stall, pc_overwrite_enable);
      end
    end
    if (fetch_fault === 1'b1) fault_seen = 1'b1;
    if (!err_en) begin
      vectors++;
      if (fetch_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL spurious_fault: fetch_fault=%b, need 0", fetch_fault);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_err   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    exp_pc     = RV32_RESET_PC;
    wait_cnt   = 0;
    req_seen   = 1'b0;
    redir_now  = 1'b0;
    fault_seen = 1'b0;
    n_acc      = 0;
    cyc        = 0;
    req_log.delete();
    acc_pc.delete();
    acc_data.delete();
    acc_cyc_q.delete();
  endtask

  task automatic run_until_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (n_acc < n && k < budget) begin
      cycle();
      k++;
    end
    vectors++;
    if (n_acc < n) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d accepts after %0d cycles, need %0d", name, n_acc, budget, n);
    end
  endtask

  task automatic test_reset();
    overlay.delete();
    lat_max = 0; ready_mode = 1; err_en = 1'b0;
    do_reset();
    wait_cnt = 5;
    cycle();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: imem_req=%b right after reset rise, need 0", bus.imem_req);
    end
    bus.instr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.instr_valid !== 1'b0 || pc_stall !== 1'b1 || pc_overwrite_enable !== 1'b0 ||
        fetch_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: valid=%b stall=%b ovr=%b fault=%b, need 0 1 0 0",
               bus.instr_valid, pc_stall, pc_overwrite_enable, fetch_fault);
    end
    vectors++;
    if (bus.instr_data !== 32'h0 || bus.instr_pc !== 32'h0 || pc_current !== RV32_RESET_PC) begin
      miscompares++;
      $display("FAIL reset_data: data=%h ipc=%h pc=%h, need 0 0 %h",
               bus.instr_data, bus.instr_pc, pc_current, RV32_RESET_PC);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_fetch();
    overlay.delete();
    overlay[32'h1000_0000] = 32'h0000_0013;
    lat_max = 0; ready_mode = 1; err_en = 1'b0;
    do_reset();
    run_until_acc(1, 20, "first_fetch");
    vectors++;
    if (req_log.size() < 1 || req_log[0] !== 32'h1000_0000) begin
      miscompares++;
      $display("FAIL first_addr: %0d reqs, first %h, need 10000000", req_log.size(),
               req_log.size() > 0 ? req_log[0] : 32'h0);
    end
    vectors++;
    if (acc_data.size() < 1 || acc_data[0] !== 32'h13 || acc_pc[0] !== 32'h1000_0000) begin
      miscompares++;
      $display("FAIL first_instr: data=%h pc=%h, need 00000013 at 10000000",
               acc_data.size() > 0 ? acc_data[0] : 32'h0, acc_pc.size() > 0 ? acc_pc[0] : 32'h0);
    end
    vectors++;
    if (acc_cyc_q.size() < 1 || acc_cyc_q[0] != 3) begin
      miscompares++;
      $display("FAIL miss_latency: valid in cycle %0d, need 3",
               acc_cyc_q.size() > 0 ? acc_cyc_q[0] : -1);
    end
    cycle();
    vectors++;
    if (pc_current !== 32'h1000_0004) begin
      miscompares++;
      $display("FAIL pc_step: pc=%h, need 10000004", pc_current);
    end
  endtask

  task automatic test_compressed_pair();
    overlay.delete();
    overlay[32'h1000_0000] = 32'h4501_4501;
    lat_max = 0; ready_mode = 1; err_en = 1'b0;
    do_reset();
    run_until_acc(2, 30, "cpair");
    vectors++;
    if (req_log.size() != 1) begin
      miscompares++;
      $display("FAIL cpair_reqs: %0d requests, need 1", req_log.size());
    end
    vectors++;
    if (acc_pc.size() < 2 || acc_pc[1] !== 32'h1000_0002 || acc_data[1] !== 32'h4501 ||
        acc_data[0] !== 32'h4501) begin
      miscompares++;
      $display("FAIL cpair_instr: second pc=%h data=%h, need 10000002 00004501",
               acc_pc.size() > 1 ? acc_pc[1] : 32'h0, acc_data.size() > 1 ? acc_data[1] : 32'h0);
    end
    vectors++;
    if (acc_cyc_q.size() < 2 || acc_cyc_q[1] - acc_cyc_q[0] != 2) begin
      miscompares++;
      $display("FAIL back_to_back: hit spacing %0d, need 2",
               acc_cyc_q.size() > 1 ? acc_cyc_q[1] - acc_cyc_q[0] : -1);
    end
  endtask

  task automatic test_straddle();
    overlay.delete();
    overlay[32'h1000_0000] = 32'h0513_4501;
    overlay[32'h1000_0004] = 32'h0000_0000;
    lat_max = 0; ready_mode = 1; err_en = 1'b0;
    do_reset();
    run_until_acc(2, 30, "straddle");
    vectors++;
    if (req_log.size() != 2 || req_log[1] !== 32'h1000_0004) begin
      miscompares++;
      $display("FAIL span_addr: %0d reqs, second %h, need 2 with 10000004", req_log.size(),
               req_log.size() > 1 ? req_log[1] : 32'h0);
    end
    vectors++;
    if (acc_data.size() < 2 || acc_data[1] !== 32'h0000_0513 || acc_pc[1] !== 32'h1000_0002) begin
      miscompares++;
      $display("FAIL span_instr: data=%h pc=%h, need 00000513 at 10000002",
               acc_data.size() > 1 ? acc_data[1] : 32'h0, acc_pc.size() > 1 ? acc_pc[1] : 32'h0);
    end
    vectors++;
    if (acc_cyc_q.size() < 2 || acc_cyc_q[1] != ack_cyc + 1) begin
      miscompares++;
      $display("FAIL span_latency: valid cycle %0d, ack cycle %0d, need ack+1",
               acc_cyc_q.size() > 1 ? acc_cyc_q[1] : -1, ack_cyc);
    end
    run_until_acc(3, 20, "after_span");
    vectors++;
    if (req_log.size() != 2 || acc_pc.size() < 3 || acc_pc[2] !== 32'h1000_0006) begin
      miscompares++;
      $display("FAIL span_buffer_hit: %0d reqs, third pc %h, need 2 reqs and 10000006",
               req_log.size(), acc_pc.size() > 2 ? acc_pc[2] : 32'h0);
    end
  endtask

  task automatic test_redirect_drain();
    overlay.delete();
    overlay[32'h1000_0000] = 32'h0010_0073;
    overlay[32'h2000_0000] = 32'h0000_0013;
    lat_max = 0; ready_mode = 1;
    err_en = 1'b1; err_addr = 32'h1000_0000;
    do_reset();
    wait_cnt = 3;
    cycle();
    redir_now = 1'b1; redir_target = 32'h2000_0001;
    cycle();
    vectors++;
    if (pc_overwrite_data !== 32'h2000_0000 || pc_overwrite_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_target: en=%b data=%h, need 1 20000000", pc_overwrite_enable, pc_overwrite_data);
    end
    run_until_acc(1, 40, "drain");
    vectors++;
    if (req_log.size() != 2 || req_log[0] !== 32'h1000_0000 || req_log[1] !== 32'h2000_0000) begin
      miscompares++;
      $display("FAIL drain_reqs: %0d reqs, second %h, need 2 with 20000000", req_log.size(),
               req_log.size() > 1 ? req_log[1] : 32'h0);
    end
    vectors++;
    if (fault_seen || acc_pc.size() < 1 || acc_pc[0] !== 32'h2000_0000 || acc_data[0] !== 32'h13) begin
      miscompares++;
      $display("FAIL drain_result: fault=%b pc=%h data=%h, need 0 20000000 00000013", fault_seen,
               acc_pc.size() > 0 ? acc_pc[0] : 32'h0, acc_data.size() > 0 ? acc_data[0] : 32'h0);
    end
    err_en = 1'b0;
  endtask

  task automatic test_fault();
    overlay.delete();
    overlay[32'h3000_0000] = 32'h0000_0013;
    lat_max = 0; ready_mode = 1;
    err_en = 1'b1; err_addr = 32'h1000_0000;
    do_reset();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      vectors++;
      if (fetch_fault !== 1'b1 || pc_stall !== 1'b1 || bus.instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fault_hold: fault=%b stall=%b valid=%b, need 1 1 0",
                 fetch_fault, pc_stall, bus.instr_valid);
      end
    end
    redir_now = 1'b1; redir_target = 32'h3000_0000;
    cycle();
    cycle();
    vectors++;
    if (fetch_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_clear: fetch_fault=%b after redirect, need 0", fetch_fault);
    end
    err_en = 1'b0;
    run_until_acc(1, 30, "fault_resume");
    vectors++;
    if (acc_pc.size() < 1 || acc_pc[0] !== 32'h3000_0000) begin
      miscompares++;
      $display("FAIL fault_resume: pc=%h, need 30000000", acc_pc.size() > 0 ? acc_pc[0] : 32'h0);
    end
  endtask

  task automatic test_redirect_vs_ready();
    int k;
    overlay.delete();
    overlay[32'h1000_0000] = 32'h0000_0013;
    overlay[32'h4000_0000] = 32'h4501_4501;
    lat_max = 0; ready_mode = 0; err_en = 1'b0;
    do_reset();
    k = 0;
    while (bus.instr_valid !== 1'b1 && k < 20) begin
      cycle();
      k++;
    end
    vectors++;
    if (bus.instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rvr_timeout: instr_valid=%b after %0d cycles, need 1", bus.instr_valid, k);
    end
    ready_mode = 1;
    redir_now = 1'b1; redir_target = 32'h4000_0000;
    cycle();
    cycle();
    vectors++;
    if (pc_current !== 32'h4000_0000 || n_acc != 0) begin
      miscompares++;
      $display("FAIL redirect_wins: pc=%h accepts=%0d, need 40000000 and 0", pc_current, n_acc);
    end
    run_until_acc(1, 30, "rvr");
    vectors++;
    if (acc_pc.size() < 1 || acc_pc[0] !== 32'h4000_0000) begin
      miscompares++;
      $display("FAIL rvr_target: pc=%h, need 40000000", acc_pc.size() > 0 ? acc_pc[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    overlay.delete();
    salt = $urandom;
    lat_max = 3; ready_mode = 2; err_en = 1'b0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        redir_now = 1'b1;
        case ($urandom_range(0, 3))
          0:       redir_target = 32'hFFFF_FFFE;
          1:       redir_target = 32'hFFFF_FFFC;
          default: redir_target = $urandom;
        endcase
      end
      cycle();
    end
    vectors++;
    if (n_acc < 200) begin
      miscompares++;
      $display("FAIL random_progress: %0d accepts in 4000 cycles, need at least 200", n_acc);
    end
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.imem_ack = 1'b0;
    bus.imem_err = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    salt = 32'h1234_5678;
    err_addr = 32'h0;
    redir_target = 32'h0;
    test_reset();
    test_first_fetch();
    test_compressed_pair();
    test_straddle();
    test_redirect_drain();
    test_fault();
    test_redirect_vs_ready();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
